// File: rtl/dump_capture.sv
// dump_capture: snapshots the six correlator arms on each dump and serves them to a host
// through a registered read port, flagging unread data (ready) and overwritten data (overrun).
module dump_capture #(
  parameter int ACC_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               dump_enable,
  input  logic [6*ACC_W-1:0] accum_in,
  input  logic               rd_en,
  input  logic [2:0]         rd_addr,
  output logic [ACC_W-1:0]   rd_data,
  output logic               rd_valid,
  output logic               ready,
  output logic               overrun
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;
  logic             r_state;
  logic             r_dump_d;
  logic             r_overrun;
  logic             r_rd_valid;
  logic [ACC_W-1:0] r_arm [6];
  logic [ACC_W-1:0] r_count;
  logic [ACC_W-1:0] r_rd_data;
  logic             w_cap;
  logic             w_rd5;
  logic             w_rd7;
  logic [ACC_W-1:0] w_rd_mux;
  // accumulators present their result one cycle after the dump pulse
  assign w_cap = r_dump_d;
  assign w_rd5 = rd_en && rd_addr == 3'd5;
  assign w_rd7 = rd_en && rd_addr == 3'd7;
  always_comb begin
    w_rd_mux = rd_addr < 3'd6 ? r_arm[rd_addr] :
               rd_addr == 3'd6 ? r_count :
               {{(ACC_W-2){1'b0}}, r_overrun, r_state};
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= EMPTY;
      r_dump_d   <= 1'b0;
      r_overrun  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_count    <= '0;
      r_rd_data  <= '0;
      for (int k = 0; k < 6; k++) r_arm[k] <= '0;
    end else begin
      r_dump_d   <= dump_enable;
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
      if (w_cap) begin
        for (int k = 0; k < 6; k++) r_arm[k] <= accum_in[k*ACC_W +: ACC_W];
        r_count <= r_count + 1'b1;
      end
      r_state   <= w_cap ? FULL : w_rd5 ? EMPTY : r_state;
      // a fresh overwrite beats a concurrent status-read clear
      r_overrun <= (w_cap && r_state == FULL && !w_rd5) ? 1'b1 : w_rd7 ? 1'b0 : r_overrun;
    end
  end
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign ready    = r_state;
  assign overrun  = r_overrun;
endmodule

// File: tb/tb_dump_capture.sv
// tb_dump_capture: directed scenarios plus randomized traffic checked against a
// transaction-level model of the capture/read rules.
module tb_dump_capture;
  localparam int W = 16;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           dump_enable = 1'b0;
  logic [6*W-1:0] accum_in = '0;
  logic           rd_en = 1'b0;
  logic [2:0]     rd_addr = '0;
  logic [W-1:0]   rd_data;
  logic           rd_valid;
  logic           ready;
  logic           overrun;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_arm [6];
  logic [W-1:0] m_count;
  logic [W-1:0] m_rd_data;
  bit m_pend, m_ready, m_ovr, m_rd_valid;

  dump_capture #(.ACC_W(W)) dut (
    .clk(clk), .rstn(rstn), .dump_enable(dump_enable), .accum_in(accum_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ready(ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [6*W-1:0] rand_set();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // drive one cycle, advance the model by the same edge, sample 1 time unit later
  task automatic cycle(input bit de, input logic [6*W-1:0] acc, input bit re, input logic [2:0] ad);
    dump_enable = de;
    accum_in = acc;
    rd_en = re;
    rd_addr = ad;
    @(posedge clk);
    if (!rstn) begin
      for (int k = 0; k < 6; k++) m_arm[k] = '0;
      m_count = '0; m_rd_data = '0; m_pend = 0; m_ready = 0; m_ovr = 0; m_rd_valid = 0;
    end else begin
      if (re) m_rd_data = ad < 6 ? m_arm[ad] : ad == 6 ? m_count : W'({m_ovr, m_ready});
      m_rd_valid = re;
      if (re && ad == 7) m_ovr = 0;
      if (m_pend) begin
        if (m_ready && !(re && ad == 5)) m_ovr = 1;
        for (int k = 0; k < 6; k++) m_arm[k] = acc[k*W +: W];
        m_count++;
        m_ready = 1;
      end else if (re && ad == 5) m_ready = 0;
      m_pend = de;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    cycle(1, rand_set(), 1, 5);
    cycle(1, rand_set(), 1, 7);
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    rstn = 1;
    cycle(0, rand_set(), 0, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_no_capture got %b exp 0", ready); end
    cycle(0, '0, 1, 6);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h0) begin errors++; $display("FAIL reset_count got %b/%h exp 1/0000", rd_valid, rd_data); end
  endtask

  task automatic test_single_capture();
    logic [6*W-1:0] a = '0;
    a[1*W +: W] = 16'd1234;
    a[5*W +: W] = 16'hFFFB;
    cycle(1, '0, 0, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_early got %b exp 0", ready); end
    cycle(0, a, 0, 0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", ready); end
    cycle(0, '0, 1, 1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'd1234) begin errors++; $display("FAIL single_ip got %b/%h exp 1/%h", rd_valid, rd_data, 16'd1234); end
    cycle(0, '0, 1, 5);
    checks++; if (rd_data !== 16'hFFFB) begin errors++; $display("FAIL single_ql got %h exp fffb", rd_data); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_clear got %b exp 0", ready); end
    cycle(0, '0, 0, 0);
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'hFFFB) begin errors++; $display("FAIL single_hold got %b/%h exp 0/fffb", rd_valid, rd_data); end
  endtask

  task automatic test_overrun();
    logic [6*W-1:0] a = rand_set();
    logic [6*W-1:0] b = rand_set();
    rstn = 0; cycle(0, '0, 0, 0); rstn = 1;
    cycle(1, '0, 0, 0);
    cycle(0, a, 0, 0);
    repeat (99) cycle(0, '0, 0, 0);
    cycle(1, '0, 0, 0);
    cycle(0, b, 0, 0);
    checks++; if (overrun !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL ovr_flags got %b%b exp 11", overrun, ready); end
    cycle(0, '0, 1, 6);
    checks++; if (rd_data !== 16'd2) begin errors++; $display("FAIL ovr_count got %h exp 0002", rd_data); end
    for (int k = 0; k < 5; k++) begin
      cycle(0, '0, 1, 3'(k));
      checks++; if (rd_data !== b[k*W +: W]) begin errors++; $display("FAIL ovr_arm%0d got %h exp %h", k, rd_data, b[k*W +: W]); end
    end
    cycle(0, '0, 1, 7);
    checks++; if (rd_data !== 16'h0003) begin errors++; $display("FAIL ovr_status got %h exp 0003", rd_data); end
    checks++; if (overrun !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL ovr_after_status got %b%b exp 01", overrun, ready); end
  endtask

  task automatic test_collision();
    logic [6*W-1:0] b = rand_set();
    logic [6*W-1:0] c = rand_set();
    cycle(0, '0, 1, 5);
    cycle(1, '0, 0, 0);
    cycle(0, b, 0, 0);
    cycle(1, '0, 0, 0);
    cycle(0, c, 1, 5);
    checks++; if (rd_data !== b[5*W +: W]) begin errors++; $display("FAIL coll_old_ql got %h exp %h", rd_data, b[5*W +: W]); end
    checks++; if (ready !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL coll_flags got r%b o%b exp r1 o0", ready, overrun); end
    cycle(0, '0, 1, 5);
    checks++; if (rd_data !== c[5*W +: W] || ready !== 1'b0) begin errors++; $display("FAIL coll_new_ql got %h/%b exp %h/0", rd_data, ready, c[5*W +: W]); end
  endtask

  task automatic test_back_to_back();
    logic [6*W-1:0] s1 = rand_set();
    logic [6*W-1:0] s2 = rand_set();
    logic [6*W-1:0] s3 = rand_set();
    logic [W-1:0] c0 = m_count;
    cycle(1, rand_set(), 0, 0);
    cycle(1, s1, 1, 0);
    cycle(1, s2, 1, 0);
    checks++; if (rd_data !== s1[W-1:0]) begin errors++; $display("FAIL b2b_cap1 got %h exp %h", rd_data, s1[W-1:0]); end
    cycle(0, s3, 1, 0);
    checks++; if (rd_data !== s2[W-1:0]) begin errors++; $display("FAIL b2b_cap2 got %h exp %h", rd_data, s2[W-1:0]); end
    cycle(0, '0, 1, 0);
    checks++; if (rd_data !== s3[W-1:0]) begin errors++; $display("FAIL b2b_cap3 got %h exp %h", rd_data, s3[W-1:0]); end
    cycle(0, '0, 1, 6);
    checks++; if (rd_data !== W'(c0 + 3)) begin errors++; $display("FAIL b2b_count got %h exp %h", rd_data, W'(c0 + 3)); end
    cycle(0, '0, 1, 5);
    checks++; if (rd_data !== s3[5*W +: W]) begin errors++; $display("FAIL b2b_ql got %h exp %h", rd_data, s3[5*W +: W]); end
  endtask

  task automatic test_wrap();
    rstn = 0; cycle(0, '0, 0, 0); rstn = 1;
    repeat (65535) cycle(1, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 6);
    checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h exp ffff", rd_data); end
    cycle(1, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 6);
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", rd_data); end
  endtask

  task automatic test_reset_mid();
    cycle(1, '0, 0, 0);
    cycle(1, rand_set(), 0, 0);
    cycle(0, rand_set(), 0, 0);
    checks++; if (overrun !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL mid_pre got %b%b exp 11", overrun, ready); end
    rstn = 0;
    cycle(1, rand_set(), 1, 7);
    checks++; if ({rd_valid, ready, overrun} !== 3'b000 || rd_data !== 16'h0) begin errors++; $display("FAIL mid_reset got v%b r%b o%b d%h exp all 0", rd_valid, ready, overrun, rd_data); end
    rstn = 1;
    cycle(0, rand_set(), 0, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_no_capture got %b exp 0", ready); end
    cycle(0, '0, 1, 6);
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL mid_count got %h exp 0000", rd_data); end
    cycle(0, '0, 1, 2);
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL mid_arm got %h exp 0000", rd_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 5) == 0, rand_set(), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
      checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin errors++; $display("FAIL rand_read@%0d got %b/%h exp %b/%h", n, rd_valid, rd_data, m_rd_valid, m_rd_data); end
      checks++; if (ready !== m_ready || overrun !== m_ovr) begin errors++; $display("FAIL rand_flags@%0d got r%b o%b exp r%b o%b", n, ready, overrun, m_ready, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_overrun();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
